fibo_seq_checker: RTL and testbench

- Receive-side companion to the Fibonacci series generator: samples a W-bit stream, locks onto the series start (0 then 1), then checks every later sample against the modulo-2^W Fibonacci recurrence.
- Reports lock status, single-cycle match/mismatch pulses and saturating counters.
- Sits downstream of the generator's series output in self-checking benches and on-chip BIST.

---
 rtl/fibo_seq_checker_pkg.sv | 13 +
 rtl/fibo_seq_checker_sat_counter.sv | 19 +
 rtl/fibo_seq_checker.sv | 97 +++++++++
 tb/tb_fibo_seq_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fibo_seq_checker_pkg.sv
// Shared definitions for the Fibonacci series checker and its companion generator bench.
package fibo_seq_checker_pkg;

    localparam int unsigned DEFAULT_W     = 4;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        GOT0   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/fibo_seq_checker_sat_counter.sv
// Enable-increment event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fibo_seq_checker.sv
// Locks onto a 0,1 series start, then checks each valid sample against the modulo-2^W
// Fibonacci recurrence, pulsing match/mismatch and counting both events.
module fibo_seq_checker
    import fibo_seq_checker_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     fibo_in,
    output logic             locked,
    output logic             match,
    output logic             mismatch,
    output logic [W-1:0]     expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    state_t       state, state_next;
    logic [W-1:0] prev, cur, prev_next, cur_next;
    logic [W-1:0] sum;
    logic         match_next, mismatch_next;

    // Carry out of the add is dropped: the series wraps modulo 2^W.
    assign sum      = prev + cur;
    assign locked   = (state == LOCKED);
    assign expected = locked ? sum : '0;

    always_comb begin
        state_next    = state;
        prev_next     = prev;
        cur_next      = cur;
        match_next    = 1'b0;
        mismatch_next = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (fibo_in == '0) state_next = GOT0;
                end
                GOT0: begin
                    if (fibo_in == W'(1)) begin
                        state_next = LOCKED;
                        prev_next  = '0;
                        cur_next   = W'(1);
                    end else if (fibo_in != '0) begin
                        state_next = HUNT;
                    end
                end
                LOCKED: begin
                    if (fibo_in == sum) begin
                        match_next = 1'b1;
                        prev_next  = cur;
                        cur_next   = fibo_in;
                    end else begin
                        // A zero sample may already be the start of a fresh series.
                        mismatch_next = 1'b1;
                        state_next    = (fibo_in == '0) ? GOT0 : HUNT;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            prev     <= '0;
            cur      <= '0;
            match    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_next;
            prev     <= prev_next;
            cur      <= cur_next;
            match    <= match_next;
            mismatch <= mismatch_next;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_next),
        .count (match_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mismatch_next),
        .count (err_count)
    );

endmodule

// File: tb/tb_fibo_seq_checker.sv
// Scoreboard bench for fibo_seq_checker: a W=4/CNT_W=8 instance plus a CNT_W=2 instance for saturation.
module tb_fibo_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] fibo_in;

    logic       locked, match, mismatch;
    logic [3:0] expected;
    logic [7:0] match_count, err_count;

    logic       s_locked, s_match, s_mismatch;
    logic [3:0] s_expected;
    logic [1:0] s_match_count, s_err_count;

    int n_vec  = 0;
    int n_miss = 0;

    fibo_seq_checker #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fibo_in(fibo_in),
        .locked(locked), .match(match), .mismatch(mismatch), .expected(expected),
        .match_count(match_count), .err_count(err_count)
    );

    fibo_seq_checker #(.W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fibo_in(fibo_in),
        .locked(s_locked), .match(s_match), .mismatch(s_mismatch), .expected(s_expected),
        .match_count(s_match_count), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        logic       mt;
        logic       mm;
        logic [3:0] ex;
        int         mc;
        int         ec;
        int         smc;
        int         sec;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int         m_state;
    logic [3:0] m_prev, m_cur;
    int         m_mc, m_ec, m_smc, m_sec;
    logic       m_mt, m_mm;

    logic [3:0] clean [11] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5, 4'd2, 4'd7};
    logic [3:0] injec [9]  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd4, 4'd0, 4'd1, 4'd1, 4'd2};
    logic [3:0] hunt  [7]  = '{4'd5, 4'd0, 4'd0, 4'd3, 4'd0, 4'd1, 4'd1};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 4'd0; m_cur = 4'd0;
        m_mc = 0; m_ec = 0; m_smc = 0; m_sec = 0;
        m_mt = 1'b0; m_mm = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d);
        logic [3:0] want;
        m_mt = 1'b0;
        m_mm = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (d == 4'd0) m_state = 1;
            end else if (m_state == 1) begin
                if (d == 4'd1) begin
                    m_state = 2; m_prev = 4'd0; m_cur = 4'd1;
                end else if (d != 4'd0) begin
                    m_state = 0;
                end
            end else begin
                want = 4'((int'(m_prev) + int'(m_cur)) % 16);
                if (d == want) begin
                    m_mt = 1'b1;
                    m_prev = m_cur; m_cur = d;
                    if (m_mc < 255) m_mc++;
                    if (m_smc < 3) m_smc++;
                end else begin
                    m_mm = 1'b1;
                    if (m_ec < 255) m_ec++;
                    if (m_sec < 3) m_sec++;
                    m_state = (d == 4'd0) ? 1 : 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.lk  = (m_state == 2);
        e.mt  = m_mt;
        e.mm  = m_mm;
        e.ex  = e.lk ? 4'((int'(m_prev) + int'(m_cur)) % 16) : 4'd0;
        e.mc  = m_mc;
        e.ec  = m_ec;
        e.smc = m_smc;
        e.sec = m_sec;
        return e;
    endfunction

    // Drive at the falling edge, let the rising edge sample, compare at the next falling edge.
    task automatic step(input bit v, input logic [3:0] d);
        exp_t e;
        in_valid = v;
        fibo_in  = d;
        model_step(v, d);
        sb.push_back(model_out());
        @(negedge clk);
        e = sb.pop_front();
        check_eq("locked", int'(locked), int'(e.lk));
        check_eq("match", int'(match), int'(e.mt));
        check_eq("mismatch", int'(mismatch), int'(e.mm));
        check_eq("expected", int'(expected), int'(e.ex));
        check_eq("match_count", int'(match_count), e.mc);
        check_eq("err_count", int'(err_count), e.ec);
        check_eq("sat_match_count", int'(s_match_count), e.smc);
        check_eq("sat_err_count", int'(s_err_count), e.sec);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_match_count", int'(match_count), 0);
        check_eq("rst_err_count", int'(err_count), 0);
        check_eq("rst_expected", int'(expected), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        fibo_in  = 4'd0;
        model_reset();
        #1;
        check_eq("init_locked", int'(locked), 0);
        check_eq("init_match", int'(match), 0);
        check_eq("init_mismatch", int'(mismatch), 0);

        // Reset then idle
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 4'(i + 3));

        // Clean lock with wrap-around
        apply_reset();
        foreach (clean[i]) step(1'b1, clean[i]);
        check_eq("clean_match_count", int'(match_count), 9);
        check_eq("clean_err_count", int'(err_count), 0);
        check_eq("clean_expected", int'(expected), 9);
        check_eq("clean_sat_count", int'(s_match_count), 3);

        // Injected error and resync
        apply_reset();
        foreach (injec[i]) step(1'b1, injec[i]);
        check_eq("inj_match_count", int'(match_count), 4);
        check_eq("inj_err_count", int'(err_count), 1);

        // Stall gaps between every sample
        apply_reset();
        foreach (clean[i]) begin
            step(1'b1, clean[i]);
            step(1'b0, 4'd15);
        end
        check_eq("stall_match_count", int'(match_count), 9);
        check_eq("stall_err_count", int'(err_count), 0);

        // Hunt filtering
        apply_reset();
        foreach (hunt[i]) step(1'b1, hunt[i]);
        check_eq("hunt_match_count", int'(match_count), 1);
        check_eq("hunt_err_count", int'(err_count), 0);

        // Asynchronous reset while locked
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, clean[i]);
        check_eq("pre_rst_locked", int'(locked), 1);
        check_eq("pre_rst_match_count", int'(match_count), 2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_locked", int'(locked), 0);
        check_eq("async_match_count", int'(match_count), 0);
        check_eq("async_err_count", int'(err_count), 0);
        check_eq("async_mismatch", int'(mismatch), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, 4'd4);
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
